multicycle_ctrl: RTL
====================

// Module: multicycle_ctrl
// PURPOSE
//  Main control FSM of the multi-cycle MIPS core. Sequences IR/PC/register-file/memory writes,
//  ALU operand and operation selection, and the immediate extender mode (sign vs zero extend)
//  per instruction. Shared memory port accessed via req/ready handshake with a wait timeout.
//  Sits between the instruction register (opcode/funct) and all datapath mux/enable controls.
// PARAMETERS
//  MEM_WAIT_MAX  16  max cycles a memory request may wait for mem_ready_i before bus error
// PORTS
//  clk_i          in   1  clock, all state updates on rising edge
//  rst_i          in   1  asynchronous, active-low reset
//  instr_op_i     in   6  opcode from IR[31:26], stable from DECODE until FETCH
//  funct_i        in   6  funct from IR[5:0]
//  zero_i         in   1  ALU zero flag, valid in BRANCH
//  mem_ready_i    in   1  memory completes the current read/write this cycle
//  mem_read_o     out  1  memory read request (held until ready)
//  mem_write_o    out  1  memory write request (held until ready)
//  i_or_d_o       out  1  0 = address from PC, 1 = from ALUOut
//  ir_write_o     out  1  load IR from memory data
//  pc_write_o     out  1  load PC
//  pc_src_o       out  2  0 = ALU result, 1 = ALUOut (branch target), 2 = jump target
//  alu_src_a_o    out  1  0 = PC, 1 = register A
//  alu_src_b_o    out  2  0 = B, 1 = const 4, 2 = extended imm, 3 = extended imm << 2
//  alu_op_o       out  2  0 = add, 1 = sub, 2 = decode funct, 3 = decode I-type opcode
//  ext_op_o       out  2  0 = sign extend, 1 = zero extend, 2 = imm << 16 (lui)
//  reg_dst_o      out  1  0 = rt, 1 = rd
//  mem_to_reg_o   out  1  0 = ALUOut, 1 = MDR
//  reg_write_o    out  1  register-file write enable
//  illegal_o      out  1  one-cycle pulse: unsupported opcode/funct decoded
//  bus_err_o      out  1  sticky: memory wait exceeded MEM_WAIT_MAX; cleared only by reset
// BEHAVIOUR
//  - Moore outputs decoded from state reg, except pc_write_o in BRANCH (uses zero_i).
//  - Reset: state=IDLE, wait counter=0, bus_err_o=0; every output 0 while in IDLE.
//  - IDLE -> FETCH unconditionally next cycle (unless bus_err_o set: stay IDLE).
//  - FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=1, alu_op=0, pc_src=0; when mem_ready_i:
//    ir_write=1, pc_write=1, -> DECODE; else stay, counter++.
//  - DECODE: alu_src_a=0, alu_src_b=3, ext_op=0 (branch target precompute); branch on opcode:
//    0x00 R -> EXEC_R; 0x08 addi,0x0A slti -> EXEC_I ext 0; 0x0C andi,0x0D ori -> EXEC_I ext 1;
//    0x0F lui -> EXEC_I ext 2; 0x23 lw,0x2B sw -> ADDR; 0x04 beq,0x05 bne -> BRANCH; 0x02 j -> JUMP;
//    else illegal_o=1 -> FETCH (PC already advanced).
//  - R-type funct allowed: 0x20,0x22,0x24,0x25,0x2A; else illegal_o pulse in DECODE -> FETCH.
//  - EXEC_R: alu_src_a=1, b=0, alu_op=2 -> WB_R (reg_dst=1, reg_write=1) -> FETCH.
//  - EXEC_I: alu_src_a=1, b=2, alu_op=3, ext per opcode -> WB_I (reg_dst=0, reg_write=1) -> FETCH.
//  - ADDR: a=1, b=2, alu_op=0, ext 0 -> MEM_RD (lw) or MEM_WR (sw).
//  - MEM_RD: mem_read=1, i_or_d=1; on ready -> WB_LD (mem_to_reg=1, reg_dst=0, reg_write=1).
//  - MEM_WR: mem_write=1, i_or_d=1; on ready -> FETCH.
//  - BRANCH: a=1, b=0, alu_op=1, pc_src=1; pc_write = zero_i (beq) / ~zero_i (bne) -> FETCH.
//  - JUMP: pc_src=2, pc_write=1 -> FETCH.
//  - ext_op held at EXEC value through WB states (stable extender output).
//  - Latency, zero-wait memory: R/I 4, lw 5, sw 4, beq/bne 3, j 3 cycles incl. FETCH.
//  - Wait counter: 0 on entry to any memory state and on ready; ready in the cycle counter
//    reaches MEM_WAIT_MAX-1 still succeeds; counter==MEM_WAIT_MAX -> bus_err_o=1, drop requests, -> IDLE.
//  - Reset mid-operation: immediate return to IDLE, requests drop asynchronously; no partial writes.
//  - mem_read_o and mem_write_o never both 1; at most one of pc_write/reg_write per non-FETCH state.
// STRUCTURE
//  - Shared package (mips_ctrl_pkg): state encoding, opcode/funct constants, alu_op, pc_src,
//    alu_src_b, ext_op encodings (also used by ALU control and extender mux).
//  - One sub-module: mem_wait_timer (clear/enable in, MEM_WAIT_MAX compare, timeout out).
// TESTING
//  - Reset then add (op 0, funct 0x20), ready always 1 -> FETCH,DECODE,EXEC_R,WB_R; reg_write 1 cycle, reg_dst=1.
//  - ori (0x0D) -> ext_op=1 in EXEC_I/WB_I; addi (0x08) -> ext_op=0; lui (0x0F) -> ext_op=2.
//  - lw with mem_ready_i low 3 cycles in MEM_RD -> mem_read held 4 cycles, WB_LD mem_to_reg=1, total 8.
//  - beq zero_i=1 -> pc_write=1,pc_src=1; bne zero_i=1 -> pc_write=0; j -> pc_src=2,pc_write=1.
//  - opcode 0x3F -> illegal_o one pulse, next state FETCH; R funct 0x03 same.
//  - FETCH with ready stuck low -> bus_err_o after MEM_WAIT_MAX=16 cycles, IDLE held; rst_i low in
//    MEM_WR -> mem_write_o 0 immediately, bus_err_o cleared.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: FSM states, opcode/funct
// constants and the mux/ALU/extender select codes used by the datapath.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC_R,
    ST_WB_R,
    ST_EXEC_I,
    ST_WB_I,
    ST_ADDR,
    ST_MEM_RD,
    ST_MEM_WR,
    ST_WB_LD,
    ST_BRANCH,
    ST_JUMP
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_FUNCT, ALU_IOP} alu_op_e;
  typedef enum logic [1:0] {PC_ALU, PC_ALUOUT, PC_JUMP, PC_RSVD} pc_src_e;
  typedef enum logic [1:0] {SRCB_REG, SRCB_FOUR, SRCB_IMM, SRCB_IMM_SH2} alu_src_b_e;
  typedef enum logic [1:0] {EXT_SIGN, EXT_ZERO, EXT_LUI, EXT_RSVD} ext_op_e;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    pc_src_e    pc_src;
    logic       alu_src_a;
    alu_src_b_e alu_src_b;
    alu_op_e    alu_op;
    ext_op_e    ext_op;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
  } ctrl_t;

  function automatic ext_op_e ext_for_op(logic [5:0] op);
    ext_op_e e;
    e = EXT_SIGN;
    if (op == OP_ANDI || op == OP_ORI) e = EXT_ZERO;
    else if (op == OP_LUI)             e = EXT_LUI;
    return e;
  endfunction

  function automatic logic r_funct_ok(logic [5:0] funct);
    return (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
           (funct == FN_OR)  || (funct == FN_SLT);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts wait cycles of an outstanding memory request and flags the cycle in which
// the request would exceed MEM_WAIT_MAX cycles without completing.
module mem_wait_timer #(
  parameter int unsigned MEM_WAIT_MAX = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic timeout_o
);

  localparam int unsigned CW = $clog2(MEM_WAIT_MAX + 1);
  localparam logic [CW-1:0] LAST = CW'(MEM_WAIT_MAX - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i)       count_d = '0;
    else if (enable_i) count_d = count_q + CW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) count_q <= '0;
    else         count_q <= count_d;
  end

  assign timeout_o = enable_i && !clear_i && (count_q == LAST);

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle MIPS core: sequences fetch/decode/execute/memory/
// writeback and drives every datapath mux and enable.
module multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] instr_op_i,
  input  logic [5:0] funct_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       i_or_d_o,
  output logic       ir_write_o,
  output logic       pc_write_o,
  output logic [1:0] pc_src_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] alu_op_o,
  output logic [1:0] ext_op_o,
  output logic       reg_dst_o,
  output logic       mem_to_reg_o,
  output logic       reg_write_o,
  output logic       illegal_o,
  output logic       bus_err_o
);

  state_e state_q, state_d;
  ctrl_t  ctrl_q;
  logic   bus_err_q;
  logic   in_mem, timeout;

  function automatic ctrl_t ctrl_for(state_e st, logic [5:0] op);
    ctrl_t c;
    c = '0;
    case (st)
      ST_FETCH:  begin c.mem_read = 1'b1; c.alu_src_b = SRCB_FOUR; end
      ST_DECODE: c.alu_src_b = SRCB_IMM_SH2;
      ST_EXEC_R: begin c.alu_src_a = 1'b1; c.alu_op = ALU_FUNCT; end
      ST_WB_R:   begin c.reg_dst = 1'b1; c.reg_write = 1'b1; end
      ST_EXEC_I: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALU_IOP;
        c.ext_op    = ext_for_op(op);
      end
      // Extender mode stays at the EXEC value so the written-back immediate is stable.
      ST_WB_I:   begin c.reg_write = 1'b1; c.ext_op = ext_for_op(op); end
      ST_ADDR:   begin c.alu_src_a = 1'b1; c.alu_src_b = SRCB_IMM; end
      ST_MEM_RD: begin c.mem_read = 1'b1; c.i_or_d = 1'b1; end
      ST_MEM_WR: begin c.mem_write = 1'b1; c.i_or_d = 1'b1; end
      ST_WB_LD:  begin c.mem_to_reg = 1'b1; c.reg_write = 1'b1; end
      ST_BRANCH: begin c.alu_src_a = 1'b1; c.alu_op = ALU_SUB; c.pc_src = PC_ALUOUT; end
      ST_JUMP:   c.pc_src = PC_JUMP;
      default:   ;
    endcase
    return c;
  endfunction

  assign in_mem = (state_q == ST_FETCH) || (state_q == ST_MEM_RD) || (state_q == ST_MEM_WR);

  mem_wait_timer #(
    .MEM_WAIT_MAX(MEM_WAIT_MAX)
  ) u_timer (
    .clk_i    (clk_i),
    .rst_ni   (rst_i),
    .clear_i  (!in_mem || mem_ready_i),
    .enable_i (in_mem && !mem_ready_i),
    .timeout_o(timeout)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (!bus_err_q) state_d = ST_FETCH;
      ST_FETCH:  if (mem_ready_i) state_d = ST_DECODE;
                 else if (timeout) state_d = ST_IDLE;
      ST_DECODE: begin
        case (instr_op_i)
          OP_RTYPE: state_d = r_funct_ok(funct_i) ? ST_EXEC_R : ST_FETCH;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI: state_d = ST_EXEC_I;
          OP_LW, OP_SW:   state_d = ST_ADDR;
          OP_BEQ, OP_BNE: state_d = ST_BRANCH;
          OP_J:           state_d = ST_JUMP;
          default:        state_d = ST_FETCH;
        endcase
      end
      ST_EXEC_R: state_d = ST_WB_R;
      ST_EXEC_I: state_d = ST_WB_I;
      ST_ADDR:   state_d = (instr_op_i == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
      ST_MEM_RD: if (mem_ready_i) state_d = ST_WB_LD;
                 else if (timeout) state_d = ST_IDLE;
      ST_MEM_WR: if (mem_ready_i) state_d = ST_FETCH;
                 else if (timeout) state_d = ST_IDLE;
      ST_WB_R, ST_WB_I, ST_WB_LD, ST_BRANCH, ST_JUMP: state_d = ST_FETCH;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Moore controls are registered from the next state so they line up with state_q.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= ST_IDLE;
      ctrl_q    <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_for(state_d, instr_op_i);
      if (timeout) bus_err_q <= 1'b1;
    end
  end

  // The only DECODE -> FETCH path is an unsupported opcode/funct.
  assign illegal_o  = (state_q == ST_DECODE) && (state_d == ST_FETCH);
  assign ir_write_o = (state_q == ST_FETCH) && mem_ready_i;
  assign pc_write_o = ((state_q == ST_FETCH) && mem_ready_i) || (state_q == ST_JUMP) ||
                      ((state_q == ST_BRANCH) && ((instr_op_i == OP_BNE) ? !zero_i : zero_i));

  assign mem_read_o   = ctrl_q.mem_read;
  assign mem_write_o  = ctrl_q.mem_write;
  assign i_or_d_o     = ctrl_q.i_or_d;
  assign pc_src_o     = ctrl_q.pc_src;
  assign alu_src_a_o  = ctrl_q.alu_src_a;
  assign alu_src_b_o  = ctrl_q.alu_src_b;
  assign alu_op_o     = ctrl_q.alu_op;
  assign ext_op_o     = ctrl_q.ext_op;
  assign reg_dst_o    = ctrl_q.reg_dst;
  assign mem_to_reg_o = ctrl_q.mem_to_reg;
  assign reg_write_o  = ctrl_q.reg_write;
  assign bus_err_o    = bus_err_q;

endmodule
